// File: rtl/custom_busmatrix_input_stage.sv
// ============================================================================
// Module      : custom_busmatrix_input_stage
// Description : AHB bus-matrix input stage, one instance per master port.
//               Sits upstream of the per-slave output arbiters. When the
//               target slave port is not granted yet, or is not ready, the
//               master's address phase is held in a holding register and
//               the master sees wait states. The live or held address and
//               control go to the output stages, and HREADYOUT/HRESP go
//               back to the master.
//
//               Ports (master side)  : HSELS, HADDRS, HTRANSS, HWRITES,
//                                      HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
//                                      HREADYS -> HREADYOUTS, HRESPS
//               Ports (output side)  : HADDRM, HTRANSM, HWRITEM, HSIZEM,
//                                      HBURSTM, HPROTM, HMASTLOCKM, trans_req
//               Ports (from output)  : active_trans, HREADYMUXM, HRESPM
//               Clock / reset        : HCLK, HRESETn (async, active low)
//
//               Optional build macro : INSTAGE_STALL_CNT_EN
//                 When defined, adds output stall_cnt[15:0]. It counts the
//                 cycles spent pending, saturates, and clears when a NONSEQ
//                 is sampled while not pending.
//
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module custom_busmatrix_input_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // Master-side address phase
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    // Feedback from the output stage
    input  logic                  active_trans,
    input  logic                  HREADYMUXM,
    input  logic                  HRESPM,
    // Toward the output stages
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  trans_req,
    // Back to the master
    output logic                  HREADYOUTS,
    output logic                  HRESPS
`ifdef INSTAGE_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;

    // ------------------------------------------------------------------
    // Address-phase qualification
    // ------------------------------------------------------------------
    logic w_sample;     // master address phase is valid this cycle
    logic w_live;       // ... and it is a real transfer (NONSEQ/SEQ)
    logic w_accept;     // output stage takes the presented transfer
    logic w_err_end;    // last cycle of an ERROR response
    logic w_pend_next;
    logic w_data_phase_next;

    logic                  r_pend;
    logic                  r_data_phase;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_trans;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [2:0]            r_burst;
    logic [3:0]            r_prot;
    logic                  r_mastlock;

    assign w_sample  = HSELS & HREADYS;
    assign w_live    = w_sample & HTRANSS[1];
    assign w_accept  = active_trans & HREADYMUXM;
    assign w_err_end = r_data_phase & HREADYMUXM & HRESPM;

    // A live request and a pending request never coexist: while pending
    // the master is stalled, so HREADYS stays low and no new phase arrives.
    // When the current data phase ends in ERROR, the queued beat is dropped
    // because the master abandons the burst.
    assign w_pend_next = (w_live | r_pend) & ~w_accept & ~w_err_end;

    // The data-phase flag only advances on a ready cycle. It then records
    // whether the output stage took a real transfer.
    assign w_data_phase_next = HREADYMUXM ? (active_trans & HTRANSM[1])
                                          : r_data_phase;

    // ------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend       <= 1'b0;
            r_data_phase <= 1'b0;
            r_addr       <= '0;
            r_trans      <= c_TRANS_IDLE;
            r_write      <= 1'b0;
            r_size       <= 3'b000;
            r_burst      <= 3'b000;
            r_prot       <= 4'b0000;
            r_mastlock   <= 1'b0;
        end else begin
            r_pend       <= w_pend_next;
            r_data_phase <= w_data_phase_next;
            if (w_sample) begin
                r_addr     <= HADDRS;
                r_trans    <= HTRANSS;
                r_write    <= HWRITES;
                r_size     <= HSIZES;
                r_burst    <= HBURSTS;
                r_prot     <= HPROTS;
                r_mastlock <= HMASTLOCKS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address/control toward the output stages
    // ------------------------------------------------------------------
    // A granted, ready transfer passes straight through, so it adds no
    // latency. Only a pending transfer is replayed from the holding regs.
    always_comb begin
        HADDRM  = r_addr;
        HTRANSM = c_TRANS_IDLE;
        HWRITEM = r_write;
        HSIZEM  = r_size;
        HBURSTM = r_burst;
        HPROTM  = r_prot;
        if (r_pend) begin
            HTRANSM = r_trans;
        end else if (w_sample) begin
            HADDRM  = HADDRS;
            HTRANSM = HTRANSS;
            HWRITEM = HWRITES;
            HSIZEM  = HSIZES;
            HBURSTM = HBURSTS;
            HPROTM  = HPROTS;
        end
    end

    // Lock is forwarded unregistered, so the arbiter lock hold takes effect
    // in the same cycle as the locked address phase.
    assign HMASTLOCKM = r_pend ? r_mastlock : HMASTLOCKS;

    assign trans_req  = r_pend | w_live;

    // ------------------------------------------------------------------
    // Response toward the master
    // ------------------------------------------------------------------
    assign HREADYOUTS = r_pend ? 1'b0 : (r_data_phase ? HREADYMUXM : 1'b1);
    assign HRESPS     = r_data_phase ? HRESPM : 1'b0;

`ifdef INSTAGE_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall counter: number of wait states caused by arbitration
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_stall_cnt <= 16'h0000;
        end else if (r_pend) begin
            if (r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
        end else if (w_sample && (HTRANSS == c_TRANS_NONSEQ)) begin
            r_stall_cnt <= 16'h0000;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_custom_busmatrix_input_stage.sv
// ============================================================================
// Module      : tb_custom_busmatrix_input_stage
// Description : Self-checking bench for custom_busmatrix_input_stage.
//               A table of per-cycle vectors (inputs plus hand-computed
//               outputs) is applied in order. Hand-written sequences follow
//               for async reset while pending and for the optional stall
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_custom_busmatrix_input_stage;

    logic        HCLK;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_trans;
    logic        HREADYMUXM;
    logic        HRESPM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;
    logic        trans_req;
    logic        HREADYOUTS;
    logic        HRESPS;
`ifdef INSTAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    custom_busmatrix_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .active_trans (active_trans),
        .HREADYMUXM   (HREADYMUXM),
        .HRESPM       (HRESPM),
        .HADDRM       (HADDRM),
        .HTRANSM      (HTRANSM),
        .HWRITEM      (HWRITEM),
        .HSIZEM       (HSIZEM),
        .HBURSTM      (HBURSTM),
        .HPROTM       (HPROTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .trans_req    (trans_req),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS)
`ifdef INSTAGE_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ctl packs {write, size[2:0], burst[2:0], prot[3:0]}
    typedef struct packed {
        logic        sel;
        logic        rdy;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [10:0] ctl;
        logic        lock;
        logic        act;
        logic        rmx;
        logic        rsp;
        logic [31:0] e_addr;
        logic [1:0]  e_trans;
        logic [10:0] e_ctl;
        logic        e_lock;
        logic        e_req;
        logic        e_rdyo;
        logic        e_rsp;
    } vec_t;

    localparam int c_NVEC = 18;
    vec_t vecs [c_NVEC];

    int n_vec;
    int n_err;

    function automatic vec_t mk(
        input logic sel, input logic rdy, input logic [1:0] trans,
        input logic [31:0] addr, input logic [10:0] ctl, input logic lock,
        input logic act, input logic rmx, input logic rsp,
        input logic [31:0] e_addr, input logic [1:0] e_trans,
        input logic [10:0] e_ctl, input logic e_lock, input logic e_req,
        input logic e_rdyo, input logic e_rsp);
        vec_t v;
        v.sel = sel;   v.rdy = rdy;   v.trans = trans; v.addr = addr;
        v.ctl = ctl;   v.lock = lock; v.act = act;     v.rmx = rmx;
        v.rsp = rsp;
        v.e_addr = e_addr; v.e_trans = e_trans; v.e_ctl = e_ctl;
        v.e_lock = e_lock; v.e_req = e_req; v.e_rdyo = e_rdyo;
        v.e_rsp = e_rsp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act_v, input logic [31:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act_v, exp_v);
        end
    endtask

    task automatic drive(input logic sel, input logic rdy, input logic [1:0] trans,
                         input logic [31:0] addr, input logic [10:0] ctl,
                         input logic lock, input logic act, input logic rmx,
                         input logic rsp);
        HSELS        = sel;
        HREADYS      = rdy;
        HTRANSS      = trans;
        HADDRS       = addr;
        {HWRITES, HSIZES, HBURSTS, HPROTS} = ctl;
        HMASTLOCKS   = lock;
        active_trans = act;
        HREADYMUXM   = rmx;
        HRESPM       = rsp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        //          sel rdy tr addr           ctl     lk act rmx rsp | e_addr         e_tr e_ctl   lk req rdy rsp
        vecs[0]  = mk(0, 1, 0, 32'h0000_0000, 11'h000, 0, 0, 1, 0,  32'h0000_0000, 0, 11'h000, 0, 0, 1, 0);
        // granted NONSEQ passes same cycle, then an IDLE data phase
        vecs[1]  = mk(1, 1, 2, 32'h2000_0000, 11'h123, 0, 1, 1, 0,  32'h2000_0000, 2, 11'h123, 0, 1, 1, 0);
        vecs[2]  = mk(1, 1, 0, 32'h2000_0004, 11'h045, 0, 1, 1, 0,  32'h2000_0004, 0, 11'h045, 0, 0, 1, 0);
        // NONSEQ without grant: three pending cycles, granted on the third
        vecs[3]  = mk(1, 1, 2, 32'h1000_0010, 11'h2B5, 1, 0, 1, 0,  32'h1000_0010, 2, 11'h2B5, 1, 1, 1, 0);
        vecs[4]  = mk(1, 0, 0, 32'hDEAD_0000, 11'h7FF, 0, 0, 1, 0,  32'h1000_0010, 2, 11'h2B5, 1, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 32'hDEAD_0000, 11'h7FF, 0, 0, 1, 0,  32'h1000_0010, 2, 11'h2B5, 1, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 32'hDEAD_0000, 11'h7FF, 0, 1, 1, 0,  32'h1000_0010, 2, 11'h2B5, 1, 1, 0, 0);
        // data phase with two slave wait states, final ready with IDLE
        vecs[7]  = mk(1, 0, 2, 32'h1000_0014, 11'h2B5, 0, 1, 0, 0,  32'h1000_0010, 0, 11'h2B5, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 2, 32'h1000_0014, 11'h2B5, 0, 1, 0, 0,  32'h1000_0010, 0, 11'h2B5, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 32'h1000_0014, 11'h2B5, 0, 1, 1, 0,  32'h1000_0014, 0, 11'h2B5, 0, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 32'h0000_0000, 11'h000, 0, 1, 0, 1,  32'h1000_0014, 0, 11'h2B5, 0, 0, 1, 0);
        // ERROR response with the next SEQ beat queued: beat dropped
        vecs[11] = mk(1, 1, 2, 32'h3000_0000, 11'h0F0, 0, 1, 1, 0,  32'h3000_0000, 2, 11'h0F0, 0, 1, 1, 0);
        vecs[12] = mk(1, 1, 3, 32'h3000_0004, 11'h0F0, 0, 1, 0, 1,  32'h3000_0004, 3, 11'h0F0, 0, 1, 0, 1);
        vecs[13] = mk(1, 0, 0, 32'h0000_0000, 11'h000, 0, 0, 1, 1,  32'h3000_0004, 3, 11'h0F0, 0, 1, 0, 1);
        vecs[14] = mk(0, 1, 0, 32'h0000_0000, 11'h000, 0, 0, 1, 1,  32'h3000_0004, 0, 11'h0F0, 0, 0, 1, 0);
        // BUSY never pends; unselected NONSEQ is ignored
        vecs[15] = mk(1, 1, 1, 32'h4000_0000, 11'h011, 1, 0, 1, 0,  32'h4000_0000, 1, 11'h011, 1, 0, 1, 0);
        vecs[16] = mk(0, 1, 0, 32'h0000_0000, 11'h000, 0, 0, 1, 0,  32'h4000_0000, 0, 11'h011, 0, 0, 1, 0);
        vecs[17] = mk(0, 1, 2, 32'h5000_0000, 11'h3FF, 0, 0, 1, 0,  32'h4000_0000, 0, 11'h011, 0, 0, 1, 0);

        // Reset state
        HRESETn = 1'b0;
        drive(0, 1, 0, 32'h0, 11'h0, 0, 0, 1, 0);
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_htransm",   -1, 32'(HTRANSM),    32'd0);
        chk("rst_trans_req", -1, 32'(trans_req),  32'd0);
        chk("rst_hreadyout", -1, 32'(HREADYOUTS), 32'd1);
        chk("rst_hresps",    -1, 32'(HRESPS),     32'd0);
        chk("rst_haddrm",    -1, HADDRM,          32'd0);
`ifdef INSTAGE_STALL_CNT_EN
        chk("rst_stall_cnt", -1, 32'(stall_cnt),  32'd0);
`endif
        HRESETn = 1'b1;

        // Table-driven sequence: inputs after posedge, check on negedge
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].sel, vecs[i].rdy, vecs[i].trans, vecs[i].addr,
                  vecs[i].ctl, vecs[i].lock, vecs[i].act, vecs[i].rmx, vecs[i].rsp);
            @(negedge HCLK);
            chk("haddrm",     i, HADDRM, vecs[i].e_addr);
            chk("htransm",    i, 32'(HTRANSM), 32'(vecs[i].e_trans));
            chk("ctlm",       i, 32'({HWRITEM, HSIZEM, HBURSTM, HPROTM}), 32'(vecs[i].e_ctl));
            chk("hmastlockm", i, 32'(HMASTLOCKM), 32'(vecs[i].e_lock));
            chk("trans_req",  i, 32'(trans_req),  32'(vecs[i].e_req));
            chk("hreadyouts", i, 32'(HREADYOUTS), 32'(vecs[i].e_rdyo));
            chk("hresps",     i, 32'(HRESPS),     32'(vecs[i].e_rsp));
            @(posedge HCLK);
            #1;
        end

        // Async reset while pending: everything returns to idle immediately
        drive(1, 1, 2, 32'h6000_0000, 11'h055, 0, 0, 1, 0);
        @(posedge HCLK);
        #1;
        drive(1, 0, 0, 32'h0, 11'h0, 0, 0, 1, 0);
        #2;
        chk("pend_trans_req", 100, 32'(trans_req),  32'd1);
        chk("pend_hreadyout", 100, 32'(HREADYOUTS), 32'd0);
        chk("pend_haddrm",    100, HADDRM,          32'h6000_0000);
        HRESETn = 1'b0;
        #1;
        chk("arst_trans_req", 101, 32'(trans_req),  32'd0);
        chk("arst_htransm",   101, 32'(HTRANSM),    32'd0);
        chk("arst_hreadyout", 101, 32'(HREADYOUTS), 32'd1);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        drive(0, 1, 0, 32'h0, 11'h0, 0, 1, 1, 0);
        @(posedge HCLK);
        #1;
        chk("noreissue_req",  102, 32'(trans_req),  32'd0);
        chk("noreissue_rdy",  102, 32'(HREADYOUTS), 32'd1);

`ifdef INSTAGE_STALL_CNT_EN
        // Five stall cycles, then an unstalled NONSEQ clears the count
        drive(1, 1, 2, 32'h7000_0000, 11'h0AA, 0, 0, 1, 0);
        @(posedge HCLK);
        #1;
        drive(1, 0, 0, 32'h0, 11'h0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge HCLK);
            #1;
        end
        active_trans = 1'b1;
        @(posedge HCLK);
        #1;
        chk("stall_cnt_5",    200, 32'(stall_cnt), 32'd5);
        chk("stall_released", 200, 32'(trans_req), 32'd0);
        drive(1, 1, 2, 32'h7000_0010, 11'h0AA, 0, 1, 1, 0);
        @(posedge HCLK);
        #1;
        chk("stall_cnt_clr",  201, 32'(stall_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
